// File: rtl/benes_route_scheduler.sv
// Round-robin owner of a pipelined Benes network: drains, reconfigures, streams, reports done.
// Beat latency NET_LAT cycles; beat_ready low outside STREAM, unbounded beat_valid stalls tolerated.
module benes_route_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CFG_W   = 64,
    parameter int NET_LAT = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*CFG_W-1:0] req_cfg,
    input  logic [NUM_REQ*8-1:0]     req_len,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     grant_valid,
    output logic [ID_W-1:0]          grant_id,
    input  logic                     beat_valid,
    output logic                     beat_ready,
    output logic [CFG_W-1:0]         net_cfg,
    output logic                     net_cfg_we,
    output logic                     net_in_valid,
    output logic                     net_out_valid,
    output logic                     done_valid,
    output logic [ID_W-1:0]          done_id,
    output logic                     busy
);
    localparam int CNT_W = $clog2(NET_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CONFIG, S_STREAM} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CFG_W-1:0]   r_net_cfg;
    logic               r_net_cfg_we;
    logic               r_cfg_loaded;
    logic [CFG_W-1:0]   r_cfg_l;
    logic [7:0]         r_len_l;
    logic [7:0]         r_beat_cnt;
    logic [ID_W-1:0]    r_last_grant;
    logic [ID_W-1:0]    r_grant_id;
    logic               r_grant_valid;
    logic [CNT_W-1:0]   r_inflight;
    logic [NET_LAT-1:0] r_sr_vld;
    logic [NET_LAT-1:0] r_sr_last;
    logic [ID_W-1:0]    r_sr_id [NET_LAT];

    logic               w_found;
    logic [ID_W-1:0]    w_win_id;
    logic [CFG_W-1:0]   w_win_cfg;
    logic [7:0]         w_win_len;
    logic               w_accept;
    logic               w_issue;
    logic               w_last;
    logic               w_load_cfg;
    logic               w_beat_ready;
    logic [CFG_W-1:0]   w_cfg_src;
    logic               w_tail_vld;

    // Round-robin search starts one past the previous winner.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_win_id = ID_W'(idx);
            end
        end
        w_win_cfg = req_cfg[int'(w_win_id)*CFG_W +: CFG_W];
        w_win_len = req_len[int'(w_win_id)*8 +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_last       = 1'b0;
        w_load_cfg   = 1'b0;
        w_beat_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_accept = 1'b1;
                    if (r_cfg_loaded && (w_win_cfg == r_net_cfg)) begin
                        w_state_nxt = S_STREAM;
                    end else if (r_inflight != '0) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_CONFIG;
                        w_load_cfg  = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (r_inflight == '0) begin
                    w_state_nxt = S_CONFIG;
                    w_load_cfg  = 1'b1;
                end
            end
            S_CONFIG: w_state_nxt = S_STREAM;
            S_STREAM: begin
                w_beat_ready = 1'b1;
                w_issue      = beat_valid;
                if (beat_valid && (r_beat_cnt == r_len_l)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The new config is registered on the edge entering CONFIG so net_cfg and its strobe coincide.
    assign w_cfg_src  = (r_state == S_IDLE) ? w_win_cfg : r_cfg_l;
    assign w_tail_vld = r_sr_vld[NET_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_net_cfg     <= '0;
            r_net_cfg_we  <= 1'b0;
            r_cfg_loaded  <= 1'b0;
            r_cfg_l       <= '0;
            r_len_l       <= '0;
            r_beat_cnt    <= '0;
            r_last_grant  <= ID_W'(NUM_REQ - 1);
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_inflight    <= '0;
        end else begin
            r_net_cfg_we <= w_load_cfg;
            if (w_load_cfg) begin
                r_net_cfg    <= w_cfg_src;
                r_cfg_loaded <= 1'b1;
            end
            if (w_accept) begin
                r_cfg_l       <= w_win_cfg;
                r_len_l       <= w_win_len;
                r_grant_id    <= w_win_id;
                r_last_grant  <= w_win_id;
                r_grant_valid <= 1'b1;
                r_beat_cnt    <= '0;
            end else if (w_issue) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
                if (w_last) r_grant_valid <= 1'b0;
            end
            case ({w_issue, w_tail_vld})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_vld  <= '0;
            r_sr_last <= '0;
            for (int i = 0; i < NET_LAT; i++) r_sr_id[i] <= '0;
        end else begin
            r_sr_vld[0]  <= w_issue;
            r_sr_last[0] <= w_issue & w_last;
            r_sr_id[0]   <= w_issue ? r_grant_id : '0;
            for (int i = 1; i < NET_LAT; i++) begin
                r_sr_vld[i]  <= r_sr_vld[i-1];
                r_sr_last[i] <= r_sr_last[i-1];
                r_sr_id[i]   <= r_sr_id[i-1];
            end
        end
    end

    // Accept pulse is combinational, so it is also masked while reset is asserted.
    assign req_ready     = (w_accept && rst_n) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_id) : '0;
    assign grant_valid   = r_grant_valid;
    assign grant_id      = r_grant_id;
    assign beat_ready    = w_beat_ready;
    assign net_cfg       = r_net_cfg;
    assign net_cfg_we    = r_net_cfg_we;
    assign net_in_valid  = w_issue;
    assign net_out_valid = w_tail_vld;
    assign done_valid    = w_tail_vld & r_sr_last[NET_LAT-1];
    assign done_id       = r_sr_id[NET_LAT-1];
    assign busy          = (r_state != S_IDLE) || (r_inflight != '0);
endmodule
